// File: rtl/dmem_access_ctrl_if.sv
// Core/memory-facing bus of dmem_access_ctrl: request/response handshake plus the data-memory port.
// slave = the controller; master = its environment (core issuing requests and the memory returning readData).
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LEN_W-1:0]  req_len;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_last;
  logic              resp_err;

  logic              mem_wen;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_len, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_last, resp_err,
           mem_wen, mem_ren, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_len, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_last, resp_err,
           mem_wen, mem_ren, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Sequences load bursts and store-fill bursts into one data-memory access per cycle.
// Optional macro DMEM_PROTECT_EN: suppresses store beats at or above PROT_BASE and reports them in resp_err.
module dmem_access_ctrl #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter int                LEN_W     = 4,
  parameter logic [ADDR_W-1:0] PROT_BASE = 8'hF0
) (
  input  logic              clk,
  input  logic              reset,
  dmem_access_ctrl_if.slave bus
);

`ifdef DMEM_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W:0]    BEAT_ONE = (LEN_W+1)'(1);

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

  // Tag travelling alongside a read issue until its data is registered.
  typedef struct packed {
    logic valid;
    logic last;
  } rd_tag_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W:0]    beats_q, beats_d;
  logic [DATA_W-1:0] wbyte_q, wbyte_d;
  logic              err_q, err_d;
  rd_tag_t           rd_tag_q, rd_tag_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_last_q, resp_last_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic last_beat;
  logic wr_blocked;

  assign last_beat  = (beats_q == BEAT_ONE);
  assign wr_blocked = PROT_EN && (cur_addr_q >= PROT_BASE);

  assign bus.mem_addr   = cur_addr_q;
  assign bus.mem_wdata  = wbyte_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_last  = resp_last_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

  // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_d      = beats_q;
    wbyte_d      = wbyte_q;
    err_d        = err_q;
    rd_tag_d     = '0;
    resp_valid_d = rd_tag_q.valid;
    resp_last_d  = rd_tag_q.valid & rd_tag_q.last;
    resp_err_d   = 1'b0;
    resp_rdata_d = rd_tag_q.valid ? bus.mem_rdata : '0;
    bus.req_ready = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_ren   = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          cur_addr_d = bus.req_addr;
          wbyte_d    = bus.req_wdata;
          beats_d    = {1'b0, bus.req_len} + BEAT_ONE;
          err_d      = 1'b0;
          state_d    = bus.req_write ? WR : RD;
        end
      end

      WR: begin
        bus.mem_wen = !wr_blocked;
        err_d       = err_q | wr_blocked;
        cur_addr_d  = cur_addr_q + ADDR_ONE;
        beats_d     = beats_q - BEAT_ONE;
        if (last_beat) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_last_d  = 1'b1;
          resp_err_d   = err_q | wr_blocked;
        end
      end

      RD: begin
        bus.mem_ren    = 1'b1;
        rd_tag_d.valid = 1'b1;
        rd_tag_d.last  = last_beat;
        cur_addr_d     = cur_addr_q + ADDR_ONE;
        beats_d        = beats_q - BEAT_ONE;
        if (last_beat) state_d = DRAIN;
      end

      DRAIN: begin
        // Final read data is registered this cycle, so its response goes out as we re-enter IDLE.
        if (rd_tag_q.valid && rd_tag_q.last) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_q      <= '0;
      wbyte_q      <= '0;
      err_q        <= 1'b0;
      rd_tag_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_q      <= beats_d;
      wbyte_q      <= wbyte_d;
      err_q        <= err_d;
      rd_tag_q     <= rd_tag_d;
      resp_valid_q <= resp_valid_d;
      resp_last_q  <= resp_last_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed bursts push expected responses, a monitor pops and compares.
// Honors DMEM_PROTECT_EN when the bundle is built with it defined.
module tb_dmem_access_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  localparam logic [7:0] PROT_BASE = 8'hF0;
`ifdef DMEM_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [7:0] rdata;
    logic       last;
    logic       err;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [7:0] mem    [256];
  logic [7:0] shadow [256];
  bit   mem_init_done = 1'b0;

  dmem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  dmem_access_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .PROT_BASE(PROT_BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(int i);
    return 8'(i) ^ 8'h3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory with 1-cycle registered readData; contents preloaded with a known pattern.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      mem_init_done <= 1'b1;
    end else if (bus.mem_wen) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Response monitor
  always @(negedge clk) begin
    if (bus.resp_valid) begin
      if (sb_q.size() == 0) begin
        check("resp_unexpected", 32'(bus.resp_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("resp_rdata", 32'(bus.resp_rdata), 32'(mon_e.rdata));
        check("resp_last",  32'(bus.resp_last),  32'(mon_e.last));
        check("resp_err",   32'(bus.resp_err),   32'(mon_e.err));
      end
    end
    if (bus.mem_wen || bus.mem_ren)
      check("wen_ren_exclusive", 32'(bus.mem_wen & bus.mem_ren), 32'd0);
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for acceptance, push expected responses, drop req_valid.
  task automatic issue(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                       input logic [3:0] len, input bit exp_resp, output int acc);
    bit         done;
    bit         err;
    int         n;
    logic [7:0] a;
    exp_t       e;
    done = 1'b0;
    acc  = -1;
    n    = int'(len) + 1;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_len   = len;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        done = 1'b1;
        acc  = cyc;
      end
    end
    if (!done) begin
      check("req_accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    if (exp_resp) begin
      if (wr) begin
        err = 1'b0;
        for (int i = 0; i < n; i++) begin
          a = addr + 8'(i);
          if (PROT_EN && a >= PROT_BASE) err = 1'b1;
          else shadow[a] = wdata;
        end
        e.cyc = acc + n + 1; e.rdata = 8'h00; e.last = 1'b1; e.err = err;
        sb_q.push_back(e);
      end else begin
        for (int i = 0; i < n; i++) begin
          a = addr + 8'(i);
          e.cyc = acc + 3 + i; e.rdata = shadow[a]; e.last = (i == n - 1); e.err = 1'b0;
          sb_q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         a0;
    int         a1;
    logic [7:0] wrap_addr [3];
    wrap_addr = '{8'hFE, 8'hFF, 8'h00};
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_len   = '0;
    for (int i = 0; i < 256; i++) shadow[i] = pat(i);

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_mem_wen",    32'(bus.mem_wen),    32'd0);
    check("reset_mem_ren",    32'(bus.mem_ren),    32'd0);
    check("reset_req_ready",  32'(bus.req_ready),  32'd1);
    check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);

    // Fill 0x10..0x13 with AA; response lands at accept+5
    sync();
    issue(1'b1, 8'h10, 8'hAA, 4'd3, 1'b1, a0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fill_wen",  32'(bus.mem_wen),  32'd1);
      check("fill_addr", 32'(bus.mem_addr), 32'h10 + 32'(i));
      check("fill_data", 32'(bus.mem_wdata), 32'hAA);
    end
    @(negedge clk);
    check("fill_wen_done", 32'(bus.mem_wen), 32'd0);

    sync();
    issue(1'b0, 8'h10, 8'h00, 4'd3, 1'b1, a0);

    // Fill across the top of memory, then read back through the wrap
    sync();
    issue(1'b1, 8'hFC, 8'h5A, 4'd4, 1'b1, a0);
    sync();
    issue(1'b0, 8'hFE, 8'h00, 4'd2, 1'b1, a0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wrap_ren",   32'(bus.mem_ren),   32'd1);
      check("wrap_addr",  32'(bus.mem_addr),  32'(wrap_addr[i]));
      check("wrap_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    check("drain_ready", 32'(bus.req_ready), 32'd0);
    check("drain_ren",   32'(bus.mem_ren),   32'd0);
    @(negedge clk);
    check("drain_done_ready", 32'(bus.req_ready), 32'd1);

    // 16-beat fill and 16-beat load
    sync();
    issue(1'b1, 8'h40, 8'h77, 4'hF, 1'b1, a0);
    sync();
    issue(1'b0, 8'h40, 8'h00, 4'hF, 1'b1, a0);

    // Reset during beat 2 of a 4-beat load: no responses may follow
    sync();
    issue(1'b0, 8'h20, 8'h00, 4'd3, 1'b0, a0);
    sync();
    reset = 1'b1;
    sync();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mid_ren",   32'(bus.mem_ren),   32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_mid_quiet", 32'(bus.resp_valid), 32'd0);
    end

    // Request held through DRAIN is accepted the cycle the controller returns to IDLE
    sync();
    issue(1'b0, 8'h30, 8'h00, 4'd0, 1'b1, a0);
    issue(1'b1, 8'h30, 8'hC3, 4'd1, 1'b1, a1);
    check("drain_accept_cycle", 32'(a1), 32'(a0 + 3));
    sync();
    issue(1'b0, 8'h30, 8'h00, 4'd1, 1'b1, a0);

    // Store straddling the protection boundary, then read it back
    sync();
    issue(1'b1, 8'hEE, 8'h55, 4'd3, 1'b1, a0);
    sync();
    issue(1'b0, 8'hEE, 8'h00, 4'd3, 1'b1, a0);

    for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
